// File: rtl/pll_reset_sequencer_if.sv
// Bundles the lock input, soft request and staged reset outputs of pll_reset_sequencer.
// LOCK_LOSS_COUNT_EN adds the lock_loss_cnt observation bus.
interface pll_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_lock;
    logic                  soft_rst;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  ready;
    logic [2:0]            state_o;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0]            lock_loss_cnt;

    modport master (output pll_lock, soft_rst, input rst_out_n, ready, state_o, lock_loss_cnt);
    modport slave  (input pll_lock, soft_rst, output rst_out_n, ready, state_o, lock_loss_cnt);
`else
    modport master (output pll_lock, soft_rst, input rst_out_n, ready, state_o);
    modport slave  (input pll_lock, soft_rst, output rst_out_n, ready, state_o);
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and releases NUM_STAGES active-low resets in order; reasserts them on lock loss
// or soft request. Optional LOCK_LOSS_COUNT_EN adds a saturating lock-loss event counter.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES      = 4,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int HOLD_CYCLES        = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.slave   bus
);

    localparam int MAX_AB  = (LOCK_STABLE_CYCLES > GLITCH_CYCLES) ? LOCK_STABLE_CYCLES : GLITCH_CYCLES;
    localparam int MAX_CD  = (STAGE_GAP > HOLD_CYCLES) ? STAGE_GAP : HOLD_CYCLES;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_STABLE    = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    logic                  sync1_r;
    logic                  lock_s_r;
    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt_s;
    logic [CW-1:0]         glitch_r;
    logic [CW-1:0]         glitch_nxt_s;
    logic [2:0]            stage_r;
    logic [2:0]            stage_nxt_s;
    logic [NUM_STAGES-1:0] rst_out_r;
    logic [NUM_STAGES-1:0] rst_nxt_s;
    logic                  ready_r;
    logic                  loss_evt_s;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            lock_s_r <= 1'b0;
        end else begin
            sync1_r  <= bus.pll_lock;
            lock_s_r <= sync1_r;
        end
    end

    // Next-state, counter and glitch-filter logic
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        glitch_nxt_s = {CW{1'b0}};
        stage_nxt_s  = stage_r;
        loss_evt_s   = 1'b0;

        // Loss filter only runs once resets have started releasing
        if ((state_r == ST_RELEASE) || (state_r == ST_RUN)) begin
            if (!lock_s_r) begin
                if (glitch_r == CW'(GLITCH_CYCLES - 1)) begin
                    loss_evt_s = 1'b1;
                end else begin
                    glitch_nxt_s = glitch_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                glitch_nxt_s = {CW{1'b0}};
            end
        end else begin
            glitch_nxt_s = {CW{1'b0}};
        end

        case (state_r)
            ST_WAIT_LOCK: begin
                if (lock_s_r) begin
                    state_nxt_s = ST_STABLE;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s_r) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (cnt_r == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt_s = ST_RELEASE;
                    stage_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_STABLE;
                end
            end
            ST_RELEASE: begin
                if (loss_evt_s) begin
                    state_nxt_s = ST_FAULT;
                end else if (cnt_r == CW'(STAGE_GAP - 1)) begin
                    if (stage_r < 3'(NUM_STAGES - 1)) begin
                        stage_nxt_s = stage_r + 3'd1;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_RUN: begin
                if (loss_evt_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (cnt_r == CW'(HOLD_CYCLES - 1)) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_LOCK;
            end
        endcase

        // Soft request overrides everything; inside FAULT it restarts the hold interval
        if (bus.soft_rst) begin
            state_nxt_s = ST_FAULT;
            if (state_r == ST_FAULT) begin
                cnt_nxt_s = {CW{1'b0}};
            end else begin
                cnt_nxt_s = cnt_nxt_s;
            end
        end else begin
            state_nxt_s = state_nxt_s;
        end

        if (state_nxt_s != state_r) begin
            cnt_nxt_s    = {CW{1'b0}};
            glitch_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s    = cnt_nxt_s;
        end
    end

    // Reset mask follows the next state so outputs switch on the transition edge
    always_comb begin
        rst_nxt_s = {NUM_STAGES{1'b0}};
        case (state_nxt_s)
            ST_RELEASE: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    rst_nxt_s[i] = (3'(i) <= stage_nxt_s) ? 1'b1 : 1'b0;
                end
            end
            ST_RUN: begin
                rst_nxt_s = {NUM_STAGES{1'b1}};
            end
            default: begin
                rst_nxt_s = {NUM_STAGES{1'b0}};
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= {CW{1'b0}};
            glitch_r  <= {CW{1'b0}};
            stage_r   <= 3'd0;
            rst_out_r <= {NUM_STAGES{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            glitch_r  <= glitch_nxt_s;
            stage_r   <= stage_nxt_s;
            rst_out_r <= rst_nxt_s;
            ready_r   <= (state_nxt_s == ST_RUN) ? 1'b1 : 1'b0;
        end
    end

    assign bus.rst_out_n = rst_out_r;
    assign bus.ready     = ready_r;
    assign bus.state_o   = state_r;

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of FAULT entries caused by lock loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_evt_s && (loss_cnt_r != 8'd255)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt_r;
`else
    // Loss events still drive FAULT entry; only the counter is absent in this build
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected per-edge outputs are queued ahead of stimulus
// and compared on the falling edge after the matching rising edge.
module tb_pll_reset_sequencer;

    localparam int NS = 3;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [2:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   base;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.NUM_STAGES(NS)) intf ();

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .GLITCH_CYCLES     (4),
        .STAGE_GAP         (4),
        .NUM_STAGES        (NS),
        .HOLD_CYCLES       (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (intf.slave)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic exp_at(input int c, input logic [2:0] r, input logic d, input logic [2:0] s);
        exp_t e;
        e.cyc = c;
        e.rst = r;
        e.rdy = d;
        e.st  = s;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            check("sb_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        #1;
    endtask

    // Reset release followed by lock rising just after edge 0; base = index of edge 0
    task automatic start_seq();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        intf.pll_lock = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc != cyc) check("sb_order", cyc, mon_e.cyc);
            check($sformatf("rst_out_n@%0d", mon_e.cyc - base), intf.rst_out_n, mon_e.rst);
            check($sformatf("ready@%0d", mon_e.cyc - base), intf.ready, mon_e.rdy);
            check($sformatf("state@%0d", mon_e.cyc - base), intf.state_o, mon_e.st);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
`ifdef LOCK_LOSS_COUNT_EN
        int exp_loss;
        int w;
`endif
        base          = 0;
        rst_n         = 1'b0;
        intf.pll_lock = 1'b0;
        intf.soft_rst = 1'b0;
        tick(3);
        check("reset_rst_out_n", intf.rst_out_n, 3'b000);
        check("reset_ready", intf.ready, 1'b0);
        check("reset_state", intf.state_o, 3'd0);
`ifdef LOCK_LOSS_COUNT_EN
        check("reset_loss_cnt", intf.lock_loss_cnt, 8'd0);
`endif

        // Test 1: nominal release timing
        start_seq();
        exp_at(base + 2,  3'b000, 1'b0, 3'd0);
        exp_at(base + 3,  3'b000, 1'b0, 3'd1);
        exp_at(base + 10, 3'b000, 1'b0, 3'd1);
        exp_at(base + 11, 3'b001, 1'b0, 3'd2);
        exp_at(base + 14, 3'b001, 1'b0, 3'd2);
        exp_at(base + 15, 3'b011, 1'b0, 3'd2);
        exp_at(base + 19, 3'b111, 1'b0, 3'd2);
        exp_at(base + 22, 3'b111, 1'b0, 3'd2);
        exp_at(base + 23, 3'b111, 1'b1, 3'd3);
        drain(40);

        // Test 3a: 3-cycle drop in RUN is filtered out
        base = cyc;
        for (int k = 1; k <= 8; k++) exp_at(base + k, 3'b111, 1'b1, 3'd3);
        intf.pll_lock = 1'b0;
        tick(3);
        intf.pll_lock = 1'b1;
        drain(20);

        // Test 3b: 4-cycle drop reaches the threshold
        base = cyc;
        exp_at(base + 5,  3'b111, 1'b1, 3'd3);
        exp_at(base + 6,  3'b000, 1'b0, 3'd4);
        exp_at(base + 11, 3'b000, 1'b0, 3'd4);
        exp_at(base + 12, 3'b000, 1'b0, 3'd0);
        exp_at(base + 13, 3'b000, 1'b0, 3'd1);
        exp_at(base + 21, 3'b001, 1'b0, 3'd2);
        exp_at(base + 33, 3'b111, 1'b1, 3'd3);
        intf.pll_lock = 1'b0;
        tick(4);
        intf.pll_lock = 1'b1;
        drain(50);
`ifdef LOCK_LOSS_COUNT_EN
        check("loss_cnt_after_drop", intf.lock_loss_cnt, 8'd1);
`endif

        // Test 4: soft request in RUN, then Test 5: async reset mid-RELEASE
        base = cyc;
        exp_at(base + 1,  3'b000, 1'b0, 3'd4);
        exp_at(base + 6,  3'b000, 1'b0, 3'd4);
        exp_at(base + 7,  3'b000, 1'b0, 3'd0);
        exp_at(base + 8,  3'b000, 1'b0, 3'd1);
        exp_at(base + 16, 3'b001, 1'b0, 3'd2);
        exp_at(base + 20, 3'b011, 1'b0, 3'd2);
        intf.soft_rst = 1'b1;
        tick(1);
        intf.soft_rst = 1'b0;
        drain(40);
`ifdef LOCK_LOSS_COUNT_EN
        check("loss_cnt_after_soft", intf.lock_loss_cnt, 8'd1);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_n", intf.rst_out_n, 3'b000);
        check("async_state", intf.state_o, 3'd0);
        check("async_ready", intf.ready, 1'b0);

        // Test 2: one-cycle drop while qualifying restarts the full interval
        intf.pll_lock = 1'b0;
        tick(2);
        start_seq();
        exp_at(base + 9,  3'b000, 1'b0, 3'd1);
        exp_at(base + 10, 3'b000, 1'b0, 3'd0);
        exp_at(base + 11, 3'b000, 1'b0, 3'd1);
        exp_at(base + 18, 3'b000, 1'b0, 3'd1);
        exp_at(base + 19, 3'b001, 1'b0, 3'd2);
        tick(7);
        intf.pll_lock = 1'b0;
        tick(1);
        intf.pll_lock = 1'b1;
        drain(30);

        // Soft request on the STABLE->RELEASE edge: FAULT wins
        rst_n         = 1'b0;
        intf.pll_lock = 1'b0;
        tick(2);
        start_seq();
        exp_at(base + 10, 3'b000, 1'b0, 3'd1);
        exp_at(base + 11, 3'b000, 1'b0, 3'd4);
        exp_at(base + 16, 3'b000, 1'b0, 3'd4);
        exp_at(base + 17, 3'b000, 1'b0, 3'd0);
        exp_at(base + 18, 3'b000, 1'b0, 3'd1);
        tick(10);
        intf.soft_rst = 1'b1;
        tick(1);
        intf.soft_rst = 1'b0;
        drain(30);

`ifdef LOCK_LOSS_COUNT_EN
        // Test 6: counter saturation
        p        = cyc;
        exp_loss = 1;
        check("loss_cnt_before_sat", intf.lock_loss_cnt, 8'd1);
        for (int i = 0; i < 300; i++) begin
            intf.pll_lock = 1'b1;
            w = 0;
            while (intf.state_o != 3'd2 && w < 40) begin tick(1); w++; end
            if (w >= 40) begin check("sat_wait_release", intf.state_o, 3'd2); break; end
            intf.pll_lock = 1'b0;
            w = 0;
            while (intf.state_o != 3'd0 && w < 40) begin tick(1); w++; end
            if (w >= 40) begin check("sat_wait_idle", intf.state_o, 3'd0); break; end
            if (exp_loss < 255) exp_loss++;
            if (i == 99) check("loss_cnt_101", intf.lock_loss_cnt, exp_loss);
        end
        check("loss_cnt_saturated", intf.lock_loss_cnt, exp_loss);
        check("loss_cnt_is_255", intf.lock_loss_cnt, 8'd255);
`else
        p = cyc;
`endif
        if (cyc < p) check("cycle_counter", cyc, p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
